insn_stream_encoder: RTL

Encodes a stream of abstract instruction requests (operation, register indices, immediate) into 32-bit RV32I words and writes them sequentially into instruction memory. It is the producer side of the instruction format the decoder consumes: it emits lw, sw, and, or, add, sub, beq and blt. It sits between the test/boot loader and the instruction-memory write port, and reports completion and overflow.

---
 rtl/insn_stream_encoder_pkg.sv | 23 ++
 rtl/insn_field_packer.sv | 22 ++
 rtl/insn_stream_encoder.sv | 93 +++++++++
 3 files changed

// File: rtl/insn_stream_encoder_pkg.sv
// insn_stream_encoder_pkg: RV32I opcode/funct constants, request op codes and encoder state type.
// INSN_ENCODER_NOP_PAD_EN adds the PAD state.
package insn_stream_encoder_pkg;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR = 3'b110;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [31:0] NOP_WORD = 32'h00000013;
  typedef enum logic [2:0] {OP_LW, OP_SW, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_BEQ, OP_BLT} req_op_e;
`ifdef INSN_ENCODER_NOP_PAD_EN
  typedef enum logic [1:0] {RUN = 2'd0, PAD = 2'd1, DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {RUN = 2'd0, DONE = 2'd2} state_e;
`endif
endpackage

// File: rtl/insn_field_packer.sv
// insn_field_packer: packs one instruction request into its 32-bit RV32I word.
module insn_field_packer
  import insn_stream_encoder_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [11:0] imm,
  output logic [31:0] word
);
  logic [31:0] r_word, b_word;
  always_comb begin
    r_word = {op == OP_SUB ? F7_SUB : F7_BASE, rs2, rs1,
              op == OP_AND ? F3_AND : op == OP_OR ? F3_OR : F3_ADD, rd, OPC_OP};
    // branch imm holds the halfword offset imm[12:1], so every bit shifts down by one
    b_word = {imm[11], imm[9:4], rs2, rs1, op == OP_BLT ? F3_BLT : F3_BEQ, imm[3:0], imm[10], OPC_BRANCH};
    word = op == OP_LW ? {imm, rs1, F3_W, rd, OPC_LOAD} :
           op == OP_SW ? {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE} :
           (op == OP_BEQ || op == OP_BLT) ? b_word : r_word;
  end
endmodule

// File: rtl/insn_stream_encoder.sv
// insn_stream_encoder: encodes instruction requests into RV32I words written sequentially to instruction memory.
// Define INSN_ENCODER_NOP_PAD_EN to fill the remaining memory with NOPs after the last instruction.
module insn_stream_encoder
  import insn_stream_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [4:0]        req_rd,
  input  logic [11:0]       req_imm,
  input  logic              req_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
`ifdef INSN_ENCODER_NOP_PAD_EN
  localparam state_e AFTER_LAST = PAD;
`else
  localparam state_e AFTER_LAST = DONE;
`endif
  state_e state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic we_q, we_d, last_q, last_d, started_q, started_d, overflow_q, overflow_d;
  logic [31:0] wdata_q, wdata_d, enc_word;
  logic in_run, in_pad, at_end, write, finish, accept;
  insn_field_packer u_packer (
    .op   (req_op),
    .rs1  (req_rs1),
    .rs2  (req_rs2),
    .rd   (req_rd),
    .imm  (req_imm),
    .word (enc_word)
  );
  always_comb begin
    in_run = state_q == RUN;
`ifdef INSN_ENCODER_NOP_PAD_EN
    in_pad = state_q == PAD;
`else
    in_pad = 1'b0;
`endif
    at_end = count_q == LAST_ADDR;
    write = (in_run && we_q) || in_pad;
    // the write now issuing is the program's last or lands on the final address: stop accepting
    finish = in_run && we_q && (last_q || at_end);
    req_ready = in_run && !finish;
    accept = req_valid && req_ready && !clear;
    state_d = clear ? RUN :
              finish ? ((last_q && !at_end) ? AFTER_LAST : DONE) :
              (in_pad && at_end) ? DONE : state_q;
    count_d = clear ? '0 : (write && !at_end) ? count_q + 1'b1 : count_q;
    we_d = accept;
    last_d = accept && req_last;
    wdata_d = accept ? enc_word : wdata_q;
    started_d = !clear && (started_q || accept);
    overflow_d = !clear && (overflow_q || (finish && !last_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      count_q <= '0;
      we_q <= 1'b0;
      last_q <= 1'b0;
      started_q <= 1'b0;
      overflow_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q <= we_d;
      last_q <= last_d;
      started_q <= started_d;
      overflow_q <= overflow_d;
      wdata_q <= wdata_d;
    end
  end
  assign mem_we = write;
  assign mem_addr = count_q;
  assign mem_wdata = in_pad ? NOP_WORD : wdata_q;
  assign busy = (in_run && started_q) || in_pad;
  assign done = state_q == DONE;
  assign overflow = overflow_q;
endmodule
